revelar_casilla: RTL and testbench

Sequential reader for the 8x8 Buscaminas mine grid. It takes one reveal request for a cell (row, col), scans the stored grid held by the mine register, and returns two results: whether that cell is a mine, and how many of its 8 neighbours are mines. It sits between the player-input/cursor logic and the display/game-state logic, and it is the consumer of the grid that the generator writes.

---
 rtl/buscaminas_pkg.sv | 15 +
 rtl/revelar_casilla_calc_vecino.sv | 37 +++
 rtl/revelar_casilla.sv | 140 ++++++++++++++
 tb/tb_revelar_casilla.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buscaminas_pkg.sv
// Shared Buscaminas definitions: grid size, cell encodings and reveal FSM states.
package buscaminas_pkg;
   localparam int GRID_N = 8;

   typedef logic [1:0] celda_t;

   localparam celda_t CELDA_NEUTRA = 2'b00;
   localparam celda_t CELDA_MINA   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } estado_rev_t;
endpackage

// File: rtl/revelar_casilla_calc_vecino.sv
// Maps a scan index (0 = centre, 1..8 = neighbours row-major) to a grid position.
// Combinational; positions off the grid are flagged, never wrapped.
module calc_vecino (
   input  logic [2:0] base_row,
   input  logic [2:0] base_col,
   input  logic [3:0] idx,
   output logic [2:0] tgt_row,
   output logic [2:0] tgt_col,
   output logic       in_bounds
);
   logic signed [3:0] dr;
   logic signed [3:0] dc;
   logic signed [3:0] r_s;
   logic signed [3:0] c_s;

   always_comb begin
      dr = 4'sd0;
      dc = 4'sd0;
      case (idx)
         4'd1: begin dr = -4'sd1; dc = -4'sd1; end
         4'd2: begin dr = -4'sd1; dc =  4'sd0; end
         4'd3: begin dr = -4'sd1; dc =  4'sd1; end
         4'd4: begin dr =  4'sd0; dc = -4'sd1; end
         4'd5: begin dr =  4'sd0; dc =  4'sd1; end
         4'd6: begin dr =  4'sd1; dc = -4'sd1; end
         4'd7: begin dr =  4'sd1; dc =  4'sd0; end
         4'd8: begin dr =  4'sd1; dc =  4'sd1; end
         default: begin dr = 4'sd0; dc = 4'sd0; end
      endcase
      r_s = signed'({1'b0, base_row}) + dr;
      c_s = signed'({1'b0, base_col}) + dc;
      // Results span -1..8; bit 3 is set exactly for -1 and 8.
      in_bounds = ~r_s[3] & ~c_s[3];
      tgt_row   = r_s[2:0];
      tgt_col   = c_s[2:0];
   end
endmodule

// File: rtl/revelar_casilla.sv
// Reveal one cell: mine flag plus neighbour mine count, resp_valid 10 cycles after accept
// (2 for a mined centre under REVELAR_FIN_TEMPRANO_EN); one request in flight, result held until resp_ready.
module revelar_casilla
   import buscaminas_pkg::*;
(
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [0:GRID_N-1][0:GRID_N-1][1:0]         gridMinasIn,
   input  logic                                       req_valid,
   output logic                                       req_ready,
   input  logic [2:0]                                 req_row,
   input  logic [2:0]                                 req_col,
   output logic                                       resp_valid,
   input  logic                                       resp_ready,
   output logic [2:0]                                 resp_row,
   output logic [2:0]                                 resp_col,
   output logic                                       resp_mine,
   output logic [3:0]                                 resp_count
);
   estado_rev_t state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [2:0]  row_q, row_d;
   logic [2:0]  col_q, col_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        mine_q, mine_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [2:0]  resp_row_q, resp_row_d;
   logic [2:0]  resp_col_q, resp_col_d;
   logic        resp_mine_q, resp_mine_d;
   logic [3:0]  resp_count_q, resp_count_d;

   logic [2:0]  tgt_row;
   logic [2:0]  tgt_col;
   logic        in_bounds;
   logic        hit;

   calc_vecino u_calc_vecino (
      .base_row  (row_q),
      .base_col  (col_q),
      .idx       (idx_q),
      .tgt_row   (tgt_row),
      .tgt_col   (tgt_col),
      .in_bounds (in_bounds)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      row_d        = row_q;
      col_d        = col_q;
      cnt_d        = cnt_q;
      mine_d       = mine_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_row_d   = resp_row_q;
      resp_col_d   = resp_col_q;
      resp_mine_d  = resp_mine_q;
      resp_count_d = resp_count_q;
      hit          = in_bounds && (gridMinasIn[tgt_row][tgt_col] == CELDA_MINA);

      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_ready_q && req_valid) begin
               row_d       = req_row;
               col_d       = req_col;
               cnt_d       = 4'd0;
               mine_d      = 1'b0;
               idx_d       = 4'd0;
               req_ready_d = 1'b0;
               state_d     = SCAN;
            end
         end
         SCAN: begin
            if (hit) begin
               if (idx_q == 4'd0) mine_d = 1'b1;
               else               cnt_d  = cnt_q + 4'd1;
            end
            if (idx_q == 4'd8) state_d = DONE;
            else               idx_d   = idx_q + 4'd1;
`ifdef REVELAR_FIN_TEMPRANO_EN
            if ((idx_q == 4'd0) && hit) state_d = DONE;
`endif
         end
         DONE: begin
            // Results are published on the first DONE cycle and frozen until taken.
            if (!resp_valid_q) begin
               resp_valid_d = 1'b1;
               resp_row_d   = row_q;
               resp_col_d   = col_q;
               resp_mine_d  = mine_q;
               resp_count_d = cnt_q;
            end else if (resp_ready) begin
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         idx_q        <= 4'd0;
         row_q        <= 3'd0;
         col_q        <= 3'd0;
         cnt_q        <= 4'd0;
         mine_q       <= 1'b0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_row_q   <= 3'd0;
         resp_col_q   <= 3'd0;
         resp_mine_q  <= 1'b0;
         resp_count_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         row_q        <= row_d;
         col_q        <= col_d;
         cnt_q        <= cnt_d;
         mine_q       <= mine_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_row_q   <= resp_row_d;
         resp_col_q   <= resp_col_d;
         resp_mine_q  <= resp_mine_d;
         resp_count_q <= resp_count_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_row   = resp_row_q;
   assign resp_col   = resp_col_q;
   assign resp_mine  = resp_mine_q;
   assign resp_count = resp_count_q;
endmodule

// File: tb/tb_revelar_casilla.sv
// Bench for revelar_casilla: directed corner cases plus random grids against a neighbourhood model.
module tb_revelar_casilla;
   logic                    clk = 1'b0;
   logic                    reset;
   logic [0:7][0:7][1:0]    grid;
   logic                    req_valid;
   logic                    req_ready;
   logic [2:0]              req_row;
   logic [2:0]              req_col;
   logic                    resp_valid;
   logic                    resp_ready;
   logic [2:0]              resp_row;
   logic [2:0]              resp_col;
   logic                    resp_mine;
   logic [3:0]              resp_count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   revelar_casilla dut (
      .clk         (clk),
      .reset       (reset),
      .gridMinasIn (grid),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_row     (req_row),
      .req_col     (req_col),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_row    (resp_row),
      .resp_col    (resp_col),
      .resp_mine   (resp_mine),
      .resp_count  (resp_count)
   );

   always #5 clk = ~clk;

   // Reference: look at the 3x3 window around (r,c), ignoring anything off the board.
   task automatic model(input int r, input int c, output bit m, output int cnt, output int lat);
      m   = (grid[r][c] == 2'b11);
      cnt = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
               if (grid[rr][cc] == 2'b11) cnt++;
         end
      lat = 10;
`ifdef REVELAR_FIN_TEMPRANO_EN
      if (m) begin
         cnt = 0;
         lat = 2;
      end
`endif
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 30; n++) begin
         if (req_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic send_req(input logic [2:0] r, input logic [2:0] c);
      req_row   = r;
      req_col   = c;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Latency = edges after the accepting edge until resp_valid is seen; 0 means it never came.
   task automatic wait_resp(output int lat);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (resp_valid === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic take_resp();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   // Runs one full request and compares every result field with the model.
   task automatic check_req(input string name, input logic [2:0] r, input logic [2:0] c);
      bit ok, m;
      int cnt, lat, got_lat;
      model(r, c, m, cnt, lat);
      wait_ready(ok);
      total_cnt++;
      if (!ok) $display("FAIL %s ready_timeout: req_ready=%b required 1", name, req_ready);
      else     pass_cnt++;
      send_req(r, c);
      wait_resp(got_lat);
      total_cnt++;
      if (got_lat !== lat) $display("FAIL %s latency: got %0d required %0d", name, got_lat, lat);
      else pass_cnt++;
      total_cnt++;
      if (resp_mine !== m) $display("FAIL %s mine: got %b required %b", name, resp_mine, m);
      else pass_cnt++;
      total_cnt++;
      if (resp_count !== 4'(cnt)) $display("FAIL %s count: got %0d required %0d", name, resp_count, cnt);
      else pass_cnt++;
      total_cnt++;
      if (resp_row !== r || resp_col !== c)
         $display("FAIL %s coords: got (%0d,%0d) required (%0d,%0d)", name, resp_row, resp_col, r, c);
      else pass_cnt++;
      take_resp();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0)
         $display("FAIL reset_handshake: valid=%b ready=%b required 0/0", resp_valid, req_ready);
      else pass_cnt++;
      total_cnt++;
      if (resp_mine !== 1'b0 || resp_count !== 4'd0 || resp_row !== 3'd0 || resp_col !== 3'd0)
         $display("FAIL reset_outputs: mine=%b count=%0d row=%0d col=%0d required all 0",
                  resp_mine, resp_count, resp_row, resp_col);
      else pass_cnt++;
      reset = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", req_ready);
      else pass_cnt++;
   endtask

   task automatic test_neutral();
      grid = '0;
      check_req("neutral_3_4", 3'd3, 3'd4);
   endtask

   task automatic test_corner();
      grid = '0;
      grid[0][1] = 2'b11;
      grid[1][0] = 2'b11;
      grid[1][1] = 2'b11;
      grid[7][7] = 2'b11;
      grid[0][7] = 2'b11;
      grid[7][0] = 2'b11;
      check_req("corner_0_0", 3'd0, 3'd0);
      check_req("corner_7_7", 3'd7, 3'd7);
   endtask

   task automatic test_all_neighbours();
      grid = '0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0)) grid[4 + dr][4 + dc] = 2'b11;
      check_req("full_ring_4_4", 3'd4, 3'd4);
   endtask

   task automatic test_other_codes();
      grid = '0;
      grid[3][3] = 2'b01;
      grid[3][4] = 2'b10;
      grid[3][5] = 2'b01;
      grid[4][3] = 2'b10;
      grid[4][5] = 2'b01;
      grid[5][3] = 2'b10;
      grid[5][4] = 2'b01;
      grid[5][5] = 2'b11;
      grid[4][4] = 2'b10;
      check_req("codes_4_4", 3'd4, 3'd4);
   endtask

   task automatic test_centre_mine();
      grid = '0;
      grid[2][2] = 2'b11;
      grid[2][3] = 2'b11;
      check_req("centre_mine_2_2", 3'd2, 3'd2);
   endtask

   task automatic test_random();
      for (int t = 0; t < 16; t++) begin
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
               grid[i][j] = 2'($urandom_range(0, 3));
         check_req($sformatf("random_%0d", t), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
   endtask

   task automatic test_back_to_back();
      bit ok, m;
      int cnt, lat, got_lat;
      int stable_bad = 0;
      grid = '0;
      grid[6][1] = 2'b11;
      grid[5][2] = 2'b11;
      grid[7][2] = 2'b01;
      model(6, 2, m, cnt, lat);
      wait_ready(ok);
      send_req(3'd6, 3'd2);
      wait_resp(got_lat);
      total_cnt++;
      if (got_lat !== lat) $display("FAIL bp_latency: got %0d required %0d", got_lat, lat);
      else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_mine !== m ||
             resp_count !== 4'(cnt) || resp_row !== 3'd6 || resp_col !== 3'd2)
            stable_bad++;
      end
      total_cnt++;
      if (stable_bad != 0) $display("FAIL bp_hold: %0d unstable cycles required 0", stable_bad);
      else pass_cnt++;
      take_resp();
      total_cnt++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL bp_after_handshake: valid=%b ready=%b required 0/1", resp_valid, req_ready);
      else pass_cnt++;
      // Next request presented immediately must be taken on the very next edge.
      send_req(3'd1, 3'd1);
      total_cnt++;
      if (req_ready !== 1'b0) $display("FAIL b2b_accept: req_ready=%b required 0", req_ready);
      else pass_cnt++;
      model(1, 1, m, cnt, lat);
      wait_resp(got_lat);
      total_cnt++;
      if (got_lat !== lat || resp_count !== 4'(cnt))
         $display("FAIL b2b_result: lat=%0d count=%0d required %0d/%0d", got_lat, resp_count, lat, cnt);
      else pass_cnt++;
      take_resp();
   endtask

   task automatic test_reset_mid_scan();
      bit ok;
      int seen = 0;
      grid = '0;
      grid[3][3] = 2'b11;
      wait_ready(ok);
      send_req(3'd3, 3'd4);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      total_cnt++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0 || resp_count !== 4'd0)
         $display("FAIL midscan_reset: valid=%b ready=%b count=%0d required 0/0/0",
                  resp_valid, req_ready, resp_count);
      else pass_cnt++;
      reset = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk); #1;
         if (resp_valid === 1'b1) seen++;
      end
      total_cnt++;
      if (seen != 0 || req_ready !== 1'b1)
         $display("FAIL midscan_no_partial: valid cycles=%0d ready=%b required 0/1", seen, req_ready);
      else pass_cnt++;
   endtask

   initial begin
      reset      = 1'b0;
      grid       = '0;
      req_valid  = 1'b0;
      req_row    = 3'd0;
      req_col    = 3'd0;
      resp_ready = 1'b0;
      test_reset();
      test_neutral();
      test_corner();
      test_all_neighbours();
      test_other_codes();
      test_centre_mine();
      test_back_to_back();
      test_reset_mid_scan();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
